riscv_mul_radix4: RTL and testbench

RISCV_MUL_RADIX4 -- requirements
Module: riscv_mul_radix4

---
 rtl/riscv_mul_pkg.sv | 64 ++++++
 rtl/riscv_booth4_enc.sv | 16 +
 rtl/riscv_mul_radix4.sv | 203 ++++++++++++++++++++
 tb/tb_riscv_mul_radix4.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mul_pkg.sv
// -----------------------------------------------------------------------------
// riscv_mul_pkg
// Purpose : shared definitions for the radix-4 Booth multiplier:
//           - op-code constants for i_riscv_mul_mulctrl
//           - FSM state encoding
//           - decoded operation type
//           - Booth digit select encoding {neg, one, two}
//           - helper functions for op decode and Booth window decode
// Ports   : none (package)
// -----------------------------------------------------------------------------
package riscv_mul_pkg;

    // Control codes; bit 3 is the start strobe.
    localparam logic [3:0] MULCTRL_MUL    = 4'b1100;
    localparam logic [3:0] MULCTRL_MULH   = 4'b1101;
    localparam logic [3:0] MULCTRL_MULHU  = 4'b1110;
    localparam logic [3:0] MULCTRL_MULHSU = 4'b1111;
    localparam logic [3:0] MULCTRL_MULW   = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mul_state_e;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHU  = 3'd2,
        OP_MULHSU = 3'd3,
        OP_MULW   = 3'd4
    } mul_op_e;

    // Booth digit: magnitude one or two, optionally negated; all zero means digit 0.
    typedef struct packed {
        logic neg;
        logic one;
        logic two;
    } booth_sel_t;

    // Any start code not listed (and MULW on a 32-bit core) behaves as MUL.
    function automatic mul_op_e decode_op(input logic [3:0] ctrl, input logic wide);
        mul_op_e op;
        case (ctrl)
            MULCTRL_MULH:   op = OP_MULH;
            MULCTRL_MULHU:  op = OP_MULHU;
            MULCTRL_MULHSU: op = OP_MULHSU;
            MULCTRL_MULW:   op = wide ? OP_MULW : OP_MUL;
            default:        op = OP_MUL;
        endcase
        return op;
    endfunction

    // Window {b[2i+1], b[2i], b[2i-1]} -> digit in {-2,-1,0,+1,+2}.
    // 111 is -0, so neg is suppressed there to keep the partial product zero.
    function automatic booth_sel_t booth_decode(input logic [2:0] window);
        booth_sel_t sel;
        sel.neg = window[2] & ~(window[1] & window[0]);
        sel.one = window[1] ^ window[0];
        sel.two = (window == 3'b011) || (window == 3'b100);
        return sel;
    endfunction

endpackage

// File: rtl/riscv_booth4_enc.sv
// -----------------------------------------------------------------------------
// riscv_booth4_enc
// Purpose : radix-4 Booth recoder for one 3-bit multiplier window.
// Ports   : i_window  [2:0]  multiplier bits {b[2i+1], b[2i], b[2i-1]}
//           o_sel            partial-product select {neg, one, two}
// -----------------------------------------------------------------------------
module riscv_booth4_enc
    import riscv_mul_pkg::*;
(
    input  logic [2:0] i_window,
    output booth_sel_t o_sel
);

    assign o_sel = booth_decode(i_window);

endmodule

// File: rtl/riscv_mul_radix4.sv
// -----------------------------------------------------------------------------
// riscv_mul_radix4
// Purpose : iterative radix-4 Booth multiplier for RISC-V M-extension ops
//           (MUL, MULH, MULHU, MULHSU, MULW), one Booth digit per cycle, with
//           zero early-out and optional reuse of the last full product.
// Ports   : i_riscv_mul_clk      clock, rising edge
//           i_riscv_mul_rst_n    asynchronous active-low reset
//           i_riscv_mul_rs1data  multiplicand
//           i_riscv_mul_rs2data  multiplier
//           i_riscv_mul_mulctrl  {start, op[2:0]}
//           i_riscv_mul_kill     flush; abandons the current operation
//           o_riscv_mul_busy     high while an operation is in flight (BUSY/DONE)
//           o_riscv_mul_valid    one-cycle pulse when o_riscv_mul_product is new
//           o_riscv_mul_product  result, held until the next valid pulse
// -----------------------------------------------------------------------------
module riscv_mul_radix4
    import riscv_mul_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter int CACHE_EN = 1
) (
    input  logic            i_riscv_mul_clk,
    input  logic            i_riscv_mul_rst_n,
    input  logic [XLEN-1:0] i_riscv_mul_rs1data,
    input  logic [XLEN-1:0] i_riscv_mul_rs2data,
    input  logic [3:0]      i_riscv_mul_mulctrl,
    input  logic            i_riscv_mul_kill,
    output logic            o_riscv_mul_busy,
    output logic            o_riscv_mul_valid,
    output logic [XLEN-1:0] o_riscv_mul_product
);

    localparam int EW = XLEN + 2;           // extended operand width
    localparam int PW = 2 * XLEN;           // product width; wrap-around above is harmless
    localparam int CW = $clog2(XLEN / 2 + 2);
    localparam logic [CW-1:0] ITER_FULL = CW'(XLEN / 2 + 1);
    localparam logic [CW-1:0] ITER_W    = CW'(16);

    mul_state_e      r_state;
    mul_op_e         r_op;
    logic [XLEN-1:0] r_rs1;
    logic [XLEN-1:0] r_rs2;
    logic [PW-1:0]   r_mcand;
    logic [EW:0]     r_mplier;
    logic [PW-1:0]   r_acc;
    logic [CW-1:0]   r_iter;
    logic            r_busy;
    logic            r_valid;
    logic [XLEN-1:0] r_product;

    logic            r_cacheValid;
    mul_op_e         r_cacheOp;
    logic [XLEN-1:0] r_cacheRs1;
    logic [XLEN-1:0] r_cacheRs2;
    logic [PW-1:0]   r_cacheProd;

    mul_op_e         w_newOp;
    logic [EW-1:0]   w_aExt;
    logic [EW-1:0]   w_bExt;
    logic            w_zero;
    logic            w_hit;
    logic [CW-1:0]   w_newIterMax;
    logic [CW-1:0]   w_iterMax;
    booth_sel_t      w_sel;
    logic [PW-1:0]   w_mag;
    logic [PW-1:0]   w_pp;
    logic [31:0]     w_low32;
    logic [XLEN-1:0] w_result;

    assign o_riscv_mul_busy    = r_busy;
    assign o_riscv_mul_valid   = r_valid;
    assign o_riscv_mul_product = r_product;

    assign w_newOp = decode_op(i_riscv_mul_mulctrl, XLEN == 64);

    // Extend both operands to XLEN+2 bits so every op runs through the same signed datapath.
    always_comb begin
        w_aExt = EW'($signed(i_riscv_mul_rs1data));
        w_bExt = EW'($signed(i_riscv_mul_rs2data));
        case (w_newOp)
            OP_MULHU: begin
                w_aExt = EW'(i_riscv_mul_rs1data);
                w_bExt = EW'(i_riscv_mul_rs2data);
            end
            OP_MULHSU: w_bExt = EW'(i_riscv_mul_rs2data);
            OP_MULW: begin
                w_aExt = EW'($signed(i_riscv_mul_rs1data[31:0]));
                w_bExt = EW'($signed(i_riscv_mul_rs2data[31:0]));
            end
            default: ;
        endcase
    end

    // A MUL hits on any stored op: the low half is the same for signed and unsigned.
    assign w_zero = (w_aExt == '0) || (w_bExt == '0);
    assign w_hit  = (CACHE_EN != 0) && r_cacheValid
                 && (i_riscv_mul_rs1data == r_cacheRs1)
                 && (i_riscv_mul_rs2data == r_cacheRs2)
                 && ((w_newOp == r_cacheOp) || (w_newOp == OP_MUL));

    assign w_newIterMax = (w_newOp == OP_MULW) ? ITER_W : ITER_FULL;
    assign w_iterMax    = (r_op == OP_MULW) ? ITER_W : ITER_FULL;

    riscv_booth4_enc u_booth (
        .i_window (r_mplier[2:0]),
        .o_sel    (w_sel)
    );

    // r_mcand is pre-shifted by 2 per iteration, so the partial product needs no barrel shifter.
    assign w_mag = w_sel.two ? {r_mcand[PW-2:0], 1'b0} : (w_sel.one ? r_mcand : '0);
    assign w_pp  = (w_mag ^ {PW{w_sel.neg}}) + PW'(w_sel.neg);

    // Result slice from the accumulated double-width product.
    always_comb begin
        w_low32  = r_acc[31:0];
        w_result = r_acc[XLEN-1:0];
        case (r_op)
            OP_MULH, OP_MULHU, OP_MULHSU: w_result = r_acc[PW-1:XLEN];
            OP_MULW:                      w_result = XLEN'($signed(w_low32));
            default: ;
        endcase
    end

    // Control FSM plus datapath and reuse store. Early-out and reuse hits enter BUSY with
    // the counter already at its end value, so they reach DONE on the following edge.
    always_ff @(posedge i_riscv_mul_clk or negedge i_riscv_mul_rst_n) begin
        if (!i_riscv_mul_rst_n) begin
            r_state      <= ST_IDLE;
            r_op         <= OP_MUL;
            r_rs1        <= '0;
            r_rs2        <= '0;
            r_mcand      <= '0;
            r_mplier     <= '0;
            r_acc        <= '0;
            r_iter       <= '0;
            r_busy       <= 1'b0;
            r_valid      <= 1'b0;
            r_product    <= '0;
            r_cacheValid <= 1'b0;
            r_cacheOp    <= OP_MUL;
            r_cacheRs1   <= '0;
            r_cacheRs2   <= '0;
            r_cacheProd  <= '0;
        end else if (i_riscv_mul_kill) begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_valid      <= 1'b0;
            r_iter       <= '0;
            r_cacheValid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_riscv_mul_mulctrl[3]) begin
                        r_state  <= ST_BUSY;
                        r_busy   <= 1'b1;
                        r_op     <= w_newOp;
                        r_rs1    <= i_riscv_mul_rs1data;
                        r_rs2    <= i_riscv_mul_rs2data;
                        r_mcand  <= PW'($signed(w_aExt));
                        r_mplier <= {w_bExt, 1'b0};
                        if (w_zero || w_hit) begin
                            r_acc  <= w_zero ? '0 : r_cacheProd;
                            r_iter <= w_newIterMax;
                        end else begin
                            r_acc  <= '0;
                            r_iter <= '0;
                        end
                    end
                end
                ST_BUSY: begin
                    if (r_iter == w_iterMax) begin
                        r_state   <= ST_DONE;
                        r_valid   <= 1'b1;
                        r_product <= w_result;
                        if ((CACHE_EN != 0) && (r_op != OP_MULW)) begin
                            r_cacheValid <= 1'b1;
                            r_cacheOp    <= r_op;
                            r_cacheRs1   <= r_rs1;
                            r_cacheRs2   <= r_rs2;
                            r_cacheProd  <= r_acc;
                        end
                    end else begin
                        r_acc    <= r_acc + w_pp;
                        r_mcand  <= r_mcand << 2;
                        r_mplier <= {{2{r_mplier[EW]}}, r_mplier[EW:2]};
                        r_iter   <= r_iter + CW'(1);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_iter  <= '0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_mul_radix4.sv
// -----------------------------------------------------------------------------
// tb_riscv_mul_radix4
// Purpose : self-checking bench for riscv_mul_radix4 (XLEN=64, CACHE_EN=1).
//           Directed vector table with hand-computed products and latencies,
//           followed by hand-written sequences for busy, kill and reset cases.
// Ports   : none (testbench)
// -----------------------------------------------------------------------------
module tb_riscv_mul_radix4;

    localparam logic [3:0] C_MUL    = 4'b1100;
    localparam logic [3:0] C_MULH   = 4'b1101;
    localparam logic [3:0] C_MULHU  = 4'b1110;
    localparam logic [3:0] C_MULHSU = 4'b1111;
    localparam logic [3:0] C_MULW   = 4'b1000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [3:0]  mulctrl;
    logic        kill;
    logic        busy;
    logic        valid;
    logic [63:0] product;

    int checksTotal  = 0;
    int checksPassed = 0;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] expProduct;
        int          expLatency;
    } vec_t;

    vec_t vectors[$];

    always #5 clk = ~clk;

    riscv_mul_radix4 #(
        .XLEN     (64),
        .CACHE_EN (1)
    ) dut (
        .i_riscv_mul_clk     (clk),
        .i_riscv_mul_rst_n   (rst_n),
        .i_riscv_mul_rs1data (rs1),
        .i_riscv_mul_rs2data (rs2),
        .i_riscv_mul_mulctrl (mulctrl),
        .i_riscv_mul_kill    (kill),
        .o_riscv_mul_busy    (busy),
        .o_riscv_mul_valid   (valid),
        .o_riscv_mul_product (product)
    );

    // Every comparison funnels through here so the counts stay consistent.
    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checksTotal++;
        if (actual === expected) checksPassed++;
        else $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, actual, expected);
    endtask

    task automatic addVec(input string name, input logic [3:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] expProduct, input int expLatency);
        vec_t v;
        v.name = name; v.op = op; v.a = a; v.b = b;
        v.expProduct = expProduct; v.expLatency = expLatency;
        vectors.push_back(v);
    endtask

    // Called at #1 after a rising edge; returns at #1 after an edge with busy low.
    task automatic waitIdle();
        int n = 0;
        while (busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) checkOutput("idleTimeout", 64'(busy), 64'd0);
    endtask

    // Drives a start for exactly one edge (the accepting edge).
    task automatic acceptOp(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        waitIdle();
        mulctrl = op; rs1 = a; rs2 = b;
        @(posedge clk); #1;
        mulctrl = 4'b0000;
    endtask

    // Counts edges after the accepting edge until valid is seen; -1 on timeout.
    task automatic waitValid(input int startCount, output int latency, output logic [63:0] prod);
        int  n = startCount;
        bit  seen = 1'b0;
        latency = -1;
        prod    = '0;
        while (!seen && n < 200) begin
            @(posedge clk); #1;
            n++;
            if (valid) begin
                seen    = 1'b1;
                latency = n;
                prod    = product;
            end
        end
    endtask

    task automatic countValids(input int cycles, output int count);
        count = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (valid) count++;
        end
    endtask

    task automatic applyStimulus(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                                 output int latency, output logic [63:0] prod);
        acceptOp(op, a, b);
        waitValid(0, latency, prod);
    endtask

    initial begin
        int          lat;
        int          nValid;
        logic [63:0] prod;

        rst_n = 1'b0; kill = 1'b0; mulctrl = 4'b0000; rs1 = '0; rs2 = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("resetBusy",    64'(busy),  64'd0);
        checkOutput("resetValid",   64'(valid), 64'd0);
        checkOutput("resetProduct", product,    64'd0);
        rst_n = 1'b1;

        // Order matters: reuse entries depend on the preceding full computation.
        addVec("mulNegSmall",      C_MUL,    64'hFFFF_FFFF_FFFF_FFFD, 64'd7,                  64'hFFFF_FFFF_FFFF_FFEB, 34);
        addVec("mulhuMax",         C_MULHU,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 34);
        addVec("mulhsuNegOne",     C_MULHSU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,                  64'hFFFF_FFFF_FFFF_FFFF, 34);
        addVec("mulwOverflow",     C_MULW,   64'h0000_0000_7FFF_FFFF, 64'd2,                  64'hFFFF_FFFF_FFFF_FFFE, 17);
        addVec("mulZeroEarly",     C_MUL,    64'd0,                   64'd5,                  64'd0,                   1);
        addVec("mulhPow32",        C_MULH,   64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000, 64'd1,                  34);
        addVec("mulReuseHit",      C_MUL,    64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000, 64'd0,                  1);
        addVec("mulhuPow32",       C_MULHU,  64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000, 64'd1,                  34);
        addVec("mulhNegOnes",      C_MULH,   64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0,                  34);
        addVec("unlistedAsMul",    4'b1001,  64'd3,                   64'd5,                  64'd15,                  34);
        addVec("mulhMinSq",        C_MULH,   64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000, 34);
        addVec("mulwIgnoresUpper", C_MULW,   64'hFFFF_FFFF_0000_0003, 64'h1234_5678_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFD, 17);
        addVec("mulwZeroLow",      C_MULW,   64'hABCD_0000_0000_0000, 64'd5,                  64'd0,                   1);
        addVec("mulhsuMinMax",     C_MULHSU, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 34);
        addVec("mulShift4",        C_MUL,    64'h1234_5678_9ABC_DEF0, 64'h10,                 64'h2345_6789_ABCD_EF00, 34);
        addVec("mulhuPow63x4",     C_MULHU,  64'h8000_0000_0000_0000, 64'd4,                  64'd2,                   34);

        for (int i = 0; i < vectors.size(); i++) begin
            applyStimulus(vectors[i].op, vectors[i].a, vectors[i].b, lat, prod);
            checkOutput({vectors[i].name, "Product"}, prod, vectors[i].expProduct);
            checkOutput({vectors[i].name, "Latency"}, 64'(lat), 64'(vectors[i].expLatency));
        end

        // A start while busy must neither disturb the running op nor be queued.
        acceptOp(C_MUL, 64'h1111, 64'd3);
        checkOutput("busyAfterAccept", 64'(busy), 64'd1);
        repeat (4) @(posedge clk);
        #1;
        mulctrl = C_MUL; rs1 = '0; rs2 = '0;
        @(posedge clk); #1;
        mulctrl = 4'b0000;
        waitValid(5, lat, prod);
        checkOutput("busyStartProduct", prod, 64'h3333);
        checkOutput("busyStartLatency", 64'(lat), 64'd34);
        @(posedge clk); #1;
        checkOutput("validOneCycle", 64'(valid), 64'd0);
        countValids(40, nValid);
        checkOutput("startNotQueued", 64'(nValid), 64'd0);

        // Kill at iteration 10: no valid, product held, reuse store dropped.
        acceptOp(C_MULH, 64'h0000_0001_0000_0001, 64'd3);
        repeat (9) @(posedge clk);
        #1;
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        checkOutput("killBusy",  64'(busy),  64'd0);
        checkOutput("killValid", 64'(valid), 64'd0);
        countValids(40, nValid);
        checkOutput("killNoValid",      64'(nValid), 64'd0);
        checkOutput("killHoldsProduct", product,     64'h3333);
        applyStimulus(C_MUL, 64'h1111, 64'd3, lat, prod);
        checkOutput("afterKillProduct", prod,      64'h3333);
        checkOutput("afterKillLatency", 64'(lat),  64'd34);

        // Kill and start on the same edge: kill wins.
        waitIdle();
        mulctrl = C_MUL; rs1 = 64'd9; rs2 = 64'd9; kill = 1'b1;
        @(posedge clk); #1;
        mulctrl = 4'b0000; kill = 1'b0;
        checkOutput("killWinsBusy", 64'(busy), 64'd0);
        countValids(40, nValid);
        checkOutput("killWinsNoValid", 64'(nValid), 64'd0);

        // Fill the store, confirm a hit, then reset mid-operation.
        applyStimulus(C_MUL, 64'h1111, 64'd3, lat, prod);
        checkOutput("refillProduct", prod, 64'h3333);
        applyStimulus(C_MUL, 64'h1111, 64'd3, lat, prod);
        checkOutput("hitLatency", 64'(lat), 64'd1);
        acceptOp(C_MULHU, 64'd5, 64'd7);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midResetBusy",    64'(busy),  64'd0);
        checkOutput("midResetValid",   64'(valid), 64'd0);
        checkOutput("midResetProduct", product,    64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        countValids(40, nValid);
        checkOutput("resetNoValid", 64'(nValid), 64'd0);
        applyStimulus(C_MUL, 64'h1111, 64'd3, lat, prod);
        checkOutput("afterResetProduct", prod,     64'h3333);
        checkOutput("afterResetLatency", 64'(lat), 64'd34);

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
